// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined barrel shifter. Each stage applies one bit
// of the shift amount (stage k shifts by 2^k). Flow control is a global stall
// on both handshakes. The carry-out is resolved at entry and travels with the
// data; the zero flag is derived from the final data.
module barrel_shifter_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASL = 3'b010;
  localparam logic [2:0] MODE_ASR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;
  localparam logic [2:0] MODE_ROR = 3'b101;

  // One partial shift by a fixed distance d (1 <= d <= WIDTH/2).
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [2:0]       mode,
                                                input int               d);
    case (mode)
      MODE_LSL, MODE_ASL: return x << d;
      MODE_LSR:           return x >> d;
      MODE_ASR:           return unsigned'($signed(x) >>> d);
      MODE_ROL:           return (x << d) | (x >> (WIDTH - d));
      MODE_ROR:           return (x >> d) | (x << (WIDTH - d));
      default:            return x;
    endcase
  endfunction

  // Stage state. Mode and the not-yet-applied amount bits are only needed by
  // the stages that follow, so the last stage does not keep them.
  logic [SHW-1:0]   valid_q, valid_d;
  logic [SHW-1:0]   carry_q, carry_d;
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [2:0]       mode_q [SHW-1];
  logic [2:0]       mode_d [SHW-1];
  logic [SHW-2:0]   rem_q  [SHW-1];
  logic [SHW-2:0]   rem_d  [SHW-1];

  logic             advance;
  logic             entry_carry;
  logic [SHW-1:0]   left_idx;
  logic [SHW-1:0]   right_idx;

  // Bit that leaves the word first/last: left moves lose in_data[WIDTH-s],
  // right moves lose in_data[s-1]; rotates report the same bit as it wraps.
  assign left_idx  = ~in_amt + SHW'(1);
  assign right_idx = in_amt - SHW'(1);

  // Carry is fully determined by the operands, so resolve it at entry.
  always_comb begin
    entry_carry = 1'b0;
    if (in_amt != '0) begin
      case (in_mode)
        MODE_LSL, MODE_ASL, MODE_ROL: entry_carry = in_data[left_idx];
        MODE_LSR, MODE_ASR, MODE_ROR: entry_carry = in_data[right_idx];
        default:                      entry_carry = 1'b0;
      endcase
    end
  end

  // Stage 0 works straight off the input port.
  assign valid_d[0] = in_valid;
  assign carry_d[0] = entry_carry;
  assign data_d[0]  = in_amt[0] ? shift_by(in_data, in_mode, 1) : in_data;
  assign mode_d[0]  = in_mode;
  assign rem_d[0]   = in_amt[SHW-1:1];

  // Stage gi applies in_amt[gi], which sits at rem bit gi-1.
  for (genvar gi = 1; gi < SHW; gi++) begin : g_stage
    assign valid_d[gi] = valid_q[gi-1];
    assign carry_d[gi] = carry_q[gi-1];
    assign data_d[gi]  = rem_q[gi-1][gi-1] ? shift_by(data_q[gi-1], mode_q[gi-1], 2 ** gi)
                                           : data_q[gi-1];
  end

  for (genvar gi = 1; gi < SHW - 1; gi++) begin : g_side
    assign mode_d[gi] = mode_q[gi-1];
    assign rem_d[gi]  = rem_q[gi-1];
  end

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance  = !valid_q[SHW-1] || out_ready;
  assign in_ready = advance;

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      data_q  <= '{default: '0};
      mode_q  <= '{default: '0};
      rem_q   <= '{default: '0};
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_carry = carry_q[SHW-1];
  assign out_zero  = (data_q[SHW-1] == '0);

endmodule
